// File: rtl/small_svf_multi.sv
// rtl/small_svf_multi.sv - time-multiplexed multi-channel state-variable filter (LPF/HPF/BPF/BSF)
// Define SMALL_SVF_SAT_FLAG_EN to add sticky per-channel saturation flags (satFlag/satClr).
module small_svf_multi #(
  parameter int  WIDTH    = 16,
  parameter int  CHANNELS = 4,
  parameter int  K0_SHIFT = 6,
  parameter int  K1_SHIFT = 6,
  parameter int  CLAMP    = 1,
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] dataIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] dataOut,
  output logic [CH_W-1:0]  outChannel
`ifdef SMALL_SVF_SAT_FLAG_EN
  ,
  output logic [CHANNELS-1:0] satFlag,
  input  logic                satClr
`endif
);

  localparam int FRAC  = 15;
  localparam int ACC_W = WIDTH + FRAC;
  localparam int CW    = ACC_W + 2;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [CW-1:0]    wide_t;

  acc_t            bp_mem [CHANNELS];
  acc_t            lp_mem [CHANNELS];
  logic [CH_W-1:0] ch;
  logic [CH_W-1:0] ch_next;
  logic            accept;

  acc_t             bp_cur, lp_cur, bp_n, lp_n;
  wide_t            x_w, hp, bp_sum, lp_sum, bsf, sel;
  logic [WIDTH-1:0] result;

  // The integer part fits WIDTH bits only if the top three bits agree.
  function automatic logic ovf(input wide_t v);
    return v[CW-1:ACC_W-1] != {3{v[CW-1]}};
  endfunction

  function automatic acc_t fit_acc(input wide_t v);
    if (CLAMP != 0 && ovf(v))
      return v[CW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return v[ACC_W-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] out_sat(input wide_t v);
    if (ovf(v))
      return v[CW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return v[ACC_W-1:FRAC];
  endfunction

  assign bp_cur = bp_mem[ch];
  assign lp_cur = lp_mem[ch];
  assign x_w    = {{2{dataIn[WIDTH-1]}}, dataIn, {FRAC{1'b0}}};
  assign hp     = x_w - wide_t'(lp_cur) - wide_t'(bp_cur);
  assign bp_sum = wide_t'(bp_cur) + (hp >>> K0_SHIFT);
  assign bp_n   = fit_acc(bp_sum);
  // The low integrator uses the already-limited band value that gets stored.
  assign lp_sum = wide_t'(lp_cur) + (wide_t'(bp_n) >>> K1_SHIFT);
  assign lp_n   = fit_acc(lp_sum);
  assign bsf    = x_w - wide_t'(bp_n);

  always_comb begin
    sel = wide_t'(lp_n);
    case (mode)
      2'd1:    sel = hp;
      2'd2:    sel = wide_t'(bp_n);
      2'd3:    sel = bsf;
      default: sel = wide_t'(lp_n);
    endcase
  end

  assign result  = out_sat(sel);
  assign inReady = !outValid || outReady;
  assign accept  = inValid && inReady;
  assign ch_next = (ch == CH_W'(CHANNELS - 1)) ? '0 : ch + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        bp_mem[i] <= '0;
        lp_mem[i] <= '0;
      end
      ch         <= '0;
      outValid   <= 1'b0;
      dataOut    <= '0;
      outChannel <= '0;
    end else if (flush) begin
      for (int i = 0; i < CHANNELS; i++) begin
        bp_mem[i] <= '0;
        lp_mem[i] <= '0;
      end
      ch       <= '0;
      outValid <= 1'b0;
    end else if (accept) begin
      bp_mem[ch] <= bp_n;
      lp_mem[ch] <= lp_n;
      ch         <= ch_next;
      outValid   <= 1'b1;
      dataOut    <= result;
      outChannel <= ch;
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

`ifdef SMALL_SVF_SAT_FLAG_EN
  logic                sat_hit;
  logic [CHANNELS-1:0] set_vec;

  assign sat_hit = ((CLAMP != 0) && (ovf(bp_sum) || ovf(lp_sum))) || ovf(sel);
  assign set_vec = (accept && !flush && sat_hit) ? (CHANNELS'(1) << ch) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      satFlag <= '0;
    else
      satFlag <= (satClr ? '0 : satFlag) | set_vec;
  end
`endif

endmodule

// File: doc/small_svf_multi.md
SMALL_SVF_MULTI -- requirements
Module: SmallSvfMulti

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the signed sample width.
REQ-002 SHALL have parameter CHANNELS, default 4, the number of time-multiplexed channels (1..64).
REQ-003 SHALL have parameter K0_SHIFT, default 6, giving band integrator gain 2^-K0_SHIFT (1..15).
REQ-004 SHALL have parameter K1_SHIFT, default 6, giving low integrator gain 2^-K1_SHIFT (1..15).
REQ-005 SHALL have parameter CLAMP, default 1: 1 saturates accumulators, 0 lets them wrap.
REQ-006 SHALL have port clk, input, 1, the single system clock.
REQ-007 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-008 SHALL have port flush, input, 1, synchronous clear of all filter state.
REQ-009 SHALL have port inValid, input, 1, input sample valid.
REQ-010 SHALL have port inReady, output, 1, input accept.
REQ-011 SHALL have port mode, input, 2, per-sample response select: 0 LPF, 1 HPF, 2 BPF, 3 BSF.
REQ-012 SHALL have port dataIn, input, WIDTH, signed sample.
REQ-013 SHALL have port outValid, output, 1, output sample valid.
REQ-014 SHALL have port outReady, input, 1, downstream accept.
REQ-015 SHALL have port dataOut, output, WIDTH, signed filtered sample.
REQ-016 SHALL have port outChannel, output, clog2(CHANNELS) (min 1), channel index of dataOut.

Function
REQ-017 SHALL accept a sample when inValid and inReady are both high on a clk rising edge.
REQ-018 SHALL drive inReady = !outValid || outReady, so throughput is one sample per cycle without backpressure.
REQ-019 SHALL assign accepted samples to channels in order 0,1,...,CHANNELS-1, then wrap to 0; the channel counter advances only on accept.
REQ-020 SHALL hold per channel a band accumulator bp and a low accumulator lp, each WIDTH+15 bits signed; the top WIDTH bits are the integer value.
REQ-021 SHALL compute on accept, at WIDTH+2 bits: hp = x - lp - bp; bpN = bp + hp*2^-K0_SHIFT; lpN = lp + bpN*2^-K1_SHIFT (arithmetic shifts, fractional bits kept).
REQ-022 SHALL write bpN and lpN back to the selected channel in the accept cycle, so a CHANNELS=1 stream sees updated state on the next sample.
REQ-023 SHALL produce LPF = lpN, HPF = hp, BPF = bpN, BSF = x - bpN, each saturated to signed WIDTH.
REQ-024 SHALL, with CLAMP=1, saturate bp and lp integer parts to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; with CLAMP=0, they wrap at their full width.
REQ-025 SHALL register dataOut and outChannel and raise outValid one cycle after accept (latency 1).
REQ-026 SHALL hold dataOut, outChannel and outValid stable while outValid && !outReady.
REQ-027 SHALL, on an accept coinciding with an output handshake, replace the output register with the new result and keep outValid high.
REQ-028 SHALL, on flush, zero all bp/lp, reset the channel counter to 0, drop outValid, and ignore any accept in that cycle.
REQ-029 SHALL make mode affect only the output selection, never the state update.

Reset
REQ-030 SHALL, while rst is high, force outValid=0, dataOut=0, outChannel=0, channel counter=0, and all bp/lp=0, independent of clk.
REQ-031 SHALL hold inReady=1 during reset; samples presented during reset are discarded.
REQ-032 SHALL resume normal operation on the first clk edge after rst deasserts.

Configuration
REQ-033 SHALL, when SMALL_SVF_SAT_FLAG_EN is defined, add output satFlag[CHANNELS-1:0] and input satClr (1 bit).
REQ-034 SHALL, with that macro, set satFlag[c] stickily on any saturation of channel c's accumulators or output; satClr clears all flags, and a set on the same edge wins.
REQ-035 SHALL, without that macro, have neither port nor any flag logic.

Verification
REQ-036 SHALL verify: CHANNELS=4, constant 8191 into all channels, mode 0 -> each channel's LPF settles to 8191 +/-2; HPF settles to 0 +/-2.
REQ-037 SHALL verify: channel 0 fed 8191, channels 1-3 fed 0 -> channels 1-3 outputs stay exactly 0 (no crosstalk).
REQ-038 SHALL verify: outReady held low for 5 cycles after one sample -> inReady=0, dataOut/outChannel unchanged; release -> exactly one output.
REQ-039 SHALL verify: flush after 100 samples -> outValid=0 next cycle; next sample is channel 0 and is computed from zero state.
REQ-040 SHALL verify: CLAMP=1, input alternating +/-32767 at Fs/2 -> no wraparound sign flips on dataOut; with SMALL_SVF_SAT_FLAG_EN defined, satFlag sets and satClr clears it.
REQ-041 SHALL verify: rst asserted mid-stream between clock edges -> outputs 0 immediately; the first accept after release is channel 0.
